// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data-memory port arbiter between CPU MEM stage and debug unit
//
// Purpose: shares one single-port, synchronous-read (read-first) data BRAM
//   between the pipeline MEM stage (CPU) and the debug unit (DBG). The CPU has
//   priority, but a starvation counter guarantees DBG a slot after STARVE_MAX
//   consecutive CPU wins. While the core is halted, DBG always wins.
// Ports:
//   clk, rstn                         clock, synchronous active-low reset
//   halted                            core stopped; DBG owns the port
//   cpu_req/we/addr/wdata, cpu_rdata  CPU side; cpu_rdata = mem_rdata
//   cpu_stall                         CPU request present but not granted
//   dbg_req/we/addr/wdata             DBG side; level request held until ack
//   dbg_rdata, dbg_ack                DBG read data and one-cycle ack
//   mem_addr/we/wdata, mem_rdata      BRAM port (1-cycle read latency)
// Configuration: define DMEM_ARB_DBG_WRITE_EN to let DBG write memory;
//   otherwise DBG is read-only (mem_we held low on DBG grants).
module dmem_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          halted,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_DBG_DATA = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;

    logic dbg_pend;
    logic cpu_grant;
    logic dbg_grant;
    logic dbg_mem_we;

`ifdef DMEM_ARB_DBG_WRITE_EN
    assign dbg_mem_we = dbg_we;
`else
    // Read-only debug port: the write enable is deliberately discarded.
    assign dbg_mem_we = dbg_we & 1'b0;
`endif

    always_comb begin
        // A DBG request is only live in IDLE; in DBG_DATA dbg_req is still
        // high while the ack is presented and must not re-arbitrate.
        dbg_pend  = dbg_req && (state_q == S_IDLE);
        cpu_grant = 1'b0;
        dbg_grant = 1'b0;
        if (halted) begin
            if (dbg_pend) begin
                dbg_grant = 1'b1;
            end else begin
                cpu_grant = cpu_req;
            end
        end else if (cpu_req && !(dbg_pend && (starve_cnt_q == CNT_MAX))) begin
            cpu_grant = 1'b1;
        end else begin
            dbg_grant = dbg_pend;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (dbg_grant) begin
            mem_addr  = dbg_addr;
            mem_we    = dbg_mem_we;
            mem_wdata = dbg_wdata;
        end else if (cpu_grant) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end
    end

    // The pipeline is frozen while halted, so a stall there would be noise.
    assign cpu_stall = cpu_req && !cpu_grant && !halted;
    assign cpu_rdata = mem_rdata;

    // Ack is gated by rstn so a reset landing on the ack cycle suppresses it.
    assign dbg_ack   = (state_q == S_DBG_DATA) && rstn;
    // BRAM data arrives in the ack cycle; pass it through then, hold after.
    assign dbg_rdata = dbg_ack ? mem_rdata : dbg_rdata_q;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        dbg_rdata_d  = dbg_rdata_q;

        if (state_q == S_DBG_DATA) begin
            state_d     = S_IDLE;
            dbg_rdata_d = mem_rdata;
        end else if (dbg_grant) begin
            state_d = S_DBG_DATA;
        end

        if (dbg_grant || !dbg_req) begin
            starve_cnt_d = '0;
        end else if (dbg_pend && cpu_grant && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            starve_cnt_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

endmodule
